// File: rtl/ufc_cmd_decoder.sv
// Far-side UFC command decoder: pops framed write/read commands from the command FIFO,
// drives a simple register bus and returns read data through the response FIFO.
module ufc_cmd_decoder #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter logic [7:0]  SYNC_BYTE     = 8'hC5,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic [31:0]              CMD_FIFO_Q,
    input  logic                     CMD_FIFO_EMPTY,
    output logic                     CMD_FIFO_RDEN,
    output logic [ADDR_WIDTH-1:0]    REG_ADDR,
    output logic [31:0]              REG_WDATA,
    output logic                     REG_WE,
    output logic                     REG_RE,
    input  logic [31:0]              REG_RDATA,
    output logic [31:0]              RSP_FIFO_Q,
    output logic                     RSP_FIFO_WREN,
    input  logic                     RSP_FIFO_FULL,
    output logic                     BUSY,
    output logic [ERR_CNT_WIDTH-1:0] ERR_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_DATA,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_PUSH
    } state_t;

    state_t                   state_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [7:0]               rem_q;
    logic [ERR_CNT_WIDTH-1:0] err_q;
    logic [ADDR_WIDTH-1:0]    reg_addr_q;
    logic [31:0]              reg_wdata_q;
    logic                     reg_we_q;
    logic                     reg_re_q;
    logic [31:0]              rsp_data_q;
    logic                     rsp_wren_q;

    logic                     pop;
    logic [7:0]               hdr_sync;
    logic [7:0]               hdr_op;
    logic [ADDR_WIDTH-1:0]    hdr_addr;
    logic [7:0]               hdr_cnt;
    logic                     hdr_ok;

    assign hdr_sync = CMD_FIFO_Q[31:24];
    assign hdr_op   = CMD_FIFO_Q[23:16];
    assign hdr_addr = CMD_FIFO_Q[8 +: ADDR_WIDTH];
    assign hdr_cnt  = CMD_FIFO_Q[7:0];
    assign hdr_ok   = (hdr_sync == SYNC_BYTE) && ((hdr_op == 8'h01) || (hdr_op == 8'h02));

    // Only IDLE (header) and WR_DATA (payload) consume command words.
    assign pop = !CMD_FIFO_EMPTY && ((state_q == S_IDLE) || (state_q == S_WR_DATA));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            err_q       <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_wren_q  <= 1'b0;
        end else begin
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
            rsp_wren_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        if (!hdr_ok) begin
                            if (err_q != '1) begin
                                err_q <= err_q + 1'b1;
                            end
                        end else if (hdr_cnt != 8'd0) begin
                            addr_q  <= hdr_addr;
                            rem_q   <= hdr_cnt;
                            state_q <= (hdr_op == 8'h01) ? S_WR_DATA : S_RD_REQ;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (pop) begin
                        reg_we_q    <= 1'b1;
                        reg_addr_q  <= addr_q;
                        reg_wdata_q <= CMD_FIFO_Q;
                        addr_q      <= addr_q + 1'b1;
                        rem_q       <= rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_RD_REQ: begin
                    // Sole writer of the response FIFO, so not-full here guarantees room for the push.
                    if (!RSP_FIFO_FULL) begin
                        reg_re_q   <= 1'b1;
                        reg_addr_q <= addr_q;
                        state_q    <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    state_q <= S_RD_PUSH;
                end
                S_RD_PUSH: begin
                    rsp_data_q <= REG_RDATA;
                    rsp_wren_q <= 1'b1;
                    addr_q     <= addr_q + 1'b1;
                    rem_q      <= rem_q - 8'd1;
                    state_q    <= (rem_q == 8'd1) ? S_IDLE : S_RD_REQ;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign CMD_FIFO_RDEN = pop;
    assign REG_ADDR      = reg_addr_q;
    assign REG_WDATA     = reg_wdata_q;
    assign REG_WE        = reg_we_q;
    assign REG_RE        = reg_re_q;
    assign RSP_FIFO_Q    = rsp_data_q;
    assign RSP_FIFO_WREN = rsp_wren_q;
    assign BUSY          = (state_q != S_IDLE);
    assign ERR_CNT       = err_q;

endmodule

// File: tb/tb_ufc_cmd_decoder.sv
// Self-checking bench for ufc_cmd_decoder: command-level reference model with
// expected write/read/response queues, directed scenarios plus randomized traffic.
module tb_ufc_cmd_decoder;

    localparam int unsigned ECW     = 4;
    localparam int unsigned ERR_MAX = (1 << ECW) - 1;

    logic           CLK = 1'b0;
    logic           RESET_N = 1'b0;
    logic [31:0]    CMD_FIFO_Q = '0;
    logic           CMD_FIFO_EMPTY = 1'b1;
    logic           CMD_FIFO_RDEN;
    logic [7:0]     REG_ADDR;
    logic [31:0]    REG_WDATA;
    logic           REG_WE;
    logic           REG_RE;
    logic [31:0]    REG_RDATA = '0;
    logic [31:0]    RSP_FIFO_Q;
    logic           RSP_FIFO_WREN;
    logic           RSP_FIFO_FULL = 1'b0;
    logic           BUSY;
    logic [ECW-1:0] ERR_CNT;

    always #5 CLK = ~CLK;

    ufc_cmd_decoder #(
        .ADDR_WIDTH   (8),
        .SYNC_BYTE    (8'hC5),
        .ERR_CNT_WIDTH(ECW)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .CMD_FIFO_Q    (CMD_FIFO_Q),
        .CMD_FIFO_EMPTY(CMD_FIFO_EMPTY),
        .CMD_FIFO_RDEN (CMD_FIFO_RDEN),
        .REG_ADDR      (REG_ADDR),
        .REG_WDATA     (REG_WDATA),
        .REG_WE        (REG_WE),
        .REG_RE        (REG_RE),
        .REG_RDATA     (REG_RDATA),
        .RSP_FIFO_Q    (RSP_FIFO_Q),
        .RSP_FIFO_WREN (RSP_FIFO_WREN),
        .RSP_FIFO_FULL (RSP_FIFO_FULL),
        .BUSY          (BUSY),
        .ERR_CNT       (ERR_CNT)
    );

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cmdq[$];
    wr_t         exp_wr[$];
    logic [7:0]  exp_re[$];
    logic [31:0] exp_rsp[$];
    int unsigned exp_err = 0;
    logic [31:0] rd_base = 32'h100;
    bit          toggle_mode = 1'b0;
    bit          rand_stall = 1'b0;
    bit          rand_full = 1'b0;
    bit          phase = 1'b0;
    int          re_seen = 0;
    int          we_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Command FIFO and register-file models, updated just after each rising edge.
    always @(posedge CLK) begin : drv
        logic       popped;
        logic       re_now;
        logic [7:0] a_now;
        popped = CMD_FIFO_RDEN;
        re_now = REG_RE;
        a_now  = REG_ADDR;
        #1;
        if (popped && cmdq.size() > 0) void'(cmdq.pop_front());
        phase = ~phase;
        CMD_FIFO_EMPTY = (cmdq.size() == 0) || (toggle_mode && phase) ||
                         (rand_stall && ($urandom_range(0, 2) == 0));
        CMD_FIFO_Q = (cmdq.size() > 0) ? cmdq[0] : $urandom();
        REG_RDATA  = re_now ? (rd_base + {24'h0, a_now}) : 32'hDEAD_BEEF;
        if (rand_full) RSP_FIFO_FULL = ($urandom_range(0, 3) == 0);
    end

    always @(negedge CLK) begin : mon
        wr_t w;
        if (RESET_N) begin
            check("rden_while_empty", {31'h0, CMD_FIFO_RDEN & CMD_FIFO_EMPTY}, 32'h0);
            check("we_and_re", {31'h0, REG_WE & REG_RE}, 32'h0);
            if (REG_WE) begin
                we_seen++;
                if (exp_wr.size() == 0) check("unexpected_we", {31'h0, REG_WE}, 32'h0);
                else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", {24'h0, REG_ADDR}, {24'h0, w.a});
                    check("wr_data", REG_WDATA, w.d);
                end
            end
            if (REG_RE) begin
                re_seen++;
                if (exp_re.size() == 0) check("unexpected_re", {31'h0, REG_RE}, 32'h0);
                else check("rd_addr", {24'h0, REG_ADDR}, {24'h0, exp_re.pop_front()});
            end
            if (RSP_FIFO_WREN) begin
                if (exp_rsp.size() == 0) check("unexpected_rsp", {31'h0, RSP_FIFO_WREN}, 32'h0);
                else check("rsp_data", RSP_FIFO_Q, exp_rsp.pop_front());
            end
        end
    end

    task automatic hdr(input logic [7:0] op, input logic [7:0] a, input logic [7:0] n);
        cmdq.push_back({8'hC5, op, a, n});
    endtask

    task automatic pay(input logic [7:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        cmdq.push_back(d);
        exp_wr.push_back(w);
    endtask

    task automatic cmd_write(input logic [7:0] a, input logic [7:0] n);
        hdr(8'h01, a, n);
        for (int i = 0; i < int'(n); i++) pay(a + 8'(i), $urandom());
    endtask

    task automatic cmd_read(input logic [7:0] a, input logic [7:0] n);
        logic [7:0] ai;
        hdr(8'h02, a, n);
        for (int i = 0; i < int'(n); i++) begin
            ai = a + 8'(i);
            exp_re.push_back(ai);
            exp_rsp.push_back(rd_base + {24'h0, ai});
        end
    endtask

    task automatic garbage(input logic [31:0] w);
        cmdq.push_back(w);
        if (exp_err < ERR_MAX) exp_err++;
    endtask

    function automatic bit drained(input bit need_idle);
        return (cmdq.size() == 0) && (exp_wr.size() == 0) && (exp_re.size() == 0) &&
               (exp_rsp.size() == 0) && (!need_idle || !BUSY);
    endfunction

    task automatic wait_done(input bit need_idle, input string tag);
        int c;
        c = 0;
        while (!drained(need_idle) && c < 3000) begin
            @(negedge CLK);
            #1;
            c++;
        end
        check({tag, "_timeout"}, {31'h0, !drained(need_idle)}, 32'h0);
        if (need_idle) begin
            @(negedge CLK);
            #1;
            check({tag, "_err_cnt"}, {28'h0, ERR_CNT}, exp_err);
            check({tag, "_busy"}, {31'h0, BUSY}, 32'h0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, {24'h0, REG_ADDR}, 32'h0);
        check({tag, "_wdata"}, REG_WDATA, 32'h0);
        check({tag, "_we_re"}, {30'h0, REG_WE, REG_RE}, 32'h0);
        check({tag, "_rsp"}, RSP_FIFO_Q, 32'h0);
        check({tag, "_wren"}, {31'h0, RSP_FIFO_WREN}, 32'h0);
        check({tag, "_busy"}, {31'h0, BUSY}, 32'h0);
        check({tag, "_err"}, {28'h0, ERR_CNT}, 32'h0);
        check({tag, "_rden"}, {31'h0, CMD_FIFO_RDEN}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0;
        int          w0;
        int          kind;
        logic [7:0]  a;
        logic [7:0]  n;
        logic [31:0] w;

        repeat (3) @(negedge CLK);
        check_reset_outputs("por");
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Basic write of two words.
        hdr(8'h01, 8'h10, 8'h02);
        pay(8'h10, 32'h0000_00AA);
        pay(8'h11, 32'h0000_00BB);
        wait_done(1'b1, "wr2");

        // Read of three words, data = addr + 0x100.
        rd_base = 32'h100;
        cmd_read(8'h20, 8'h03);
        wait_done(1'b1, "rd3");

        // Bad sync, bad opcode, zero-length no-op, then a normal write.
        garbage(32'h1234_5678);
        garbage(32'hC5FF_0001);
        hdr(8'h01, 8'h60, 8'h00);
        cmd_write(8'h50, 8'h02);
        wait_done(1'b1, "errs");

        // Response FIFO full holds off the read request; address wraps FE, FF, 00.
        RSP_FIFO_FULL = 1'b1;
        cmd_read(8'hFE, 8'h03);
        r0 = re_seen;
        repeat (20) @(negedge CLK);
        #1;
        check("full_re_held", re_seen - r0, 32'h0);
        check("full_busy", {31'h0, BUSY}, 32'h1);
        RSP_FIFO_FULL = 1'b0;
        wait_done(1'b1, "full");

        // Write with EMPTY toggling every cycle.
        toggle_mode = 1'b1;
        w0 = we_seen;
        cmd_write(8'h30, 8'h03);
        wait_done(1'b1, "toggle");
        check("toggle_we_count", we_seen - w0, 32'h3);
        toggle_mode = 1'b0;

        // Reset in the middle of a 4-word write after 2 payload words.
        hdr(8'h01, 8'h40, 8'h04);
        pay(8'h40, 32'hA5A5_0040);
        pay(8'h41, 32'hA5A5_0041);
        wait_done(1'b0, "midcmd");
        repeat (2) @(negedge CLK);
        #1;
        check("midcmd_busy_before", {31'h0, BUSY}, 32'h1);
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_err = 0;
        @(negedge CLK);
        RESET_N = 1'b1;
        garbage(32'h0000_00CC);
        garbage(32'h0000_00DD);
        wait_done(1'b1, "resync");

        // Randomized mixed traffic with random FIFO stalls and backpressure.
        rand_stall = 1'b1;
        rand_full  = 1'b1;
        rd_base    = $urandom();
        for (int i = 0; i < 48; i++) begin
            kind = $urandom_range(0, 2);
            a    = ($urandom_range(0, 1) == 1) ? 8'(8'hF8 + $urandom_range(0, 7)) : 8'($urandom());
            n    = 8'($urandom_range(0, 5));
            if (kind == 0) cmd_write(a, n);
            else if (kind == 1) cmd_read(a, n);
            else begin
                w = $urandom();
                if ($urandom_range(0, 1) == 1) w[31:24] = 8'hC5;
                if (w[31:24] == 8'hC5 && (w[23:16] == 8'h01 || w[23:16] == 8'h02)) w[23:16] = 8'h07;
                garbage(w);
            end
            if (i % 8 == 7) wait_done(1'b1, "rand");
        end
        rand_stall = 1'b0;
        rand_full  = 1'b0;
        RSP_FIFO_FULL = 1'b0;

        // Saturation of the error counter after a fresh reset.
        @(negedge CLK);
        RESET_N = 1'b0;
        exp_err = 0;
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 20; i++) garbage(32'h0000_0100 + 32'(i));
        cmd_write(8'h70, 8'h01);
        wait_done(1'b1, "sat");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
